rom_burst_reader: RTL and testbench

ROM_BURST_READER -- requirements
Module: rom_burst_reader

---
 rtl/rom_burst_pkg.sv | 14 +
 rtl/rom_burst_fifo.sv | 65 ++++++
 rtl/rom_burst_reader.sv | 173 +++++++++++++++++
 tb/tb_rom_burst_reader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rom_burst_pkg.sv
// Shared types and constants for the ROM burst reader.
package rom_burst_pkg;

    // Output buffer depth; also bounds outstanding ROM reads.
    localparam int unsigned FIFO_DEPTH = 3;
    localparam int unsigned FIFO_CW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage : rom_burst_pkg

// File: rtl/rom_burst_fifo.sv
// Small shift-register FIFO: head always sits in entry 0 so the read data
// comes straight from a register. Synchronous active-high reset.
module rom_burst_fifo
    import rom_burst_pkg::*;
#(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  rd_data_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] wr_idx;
    logic          valid_q;
    logic          do_pop;
    logic          do_push;

    // Next contents: shift down on pop, then write behind the surviving entries.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        wr_idx  = count_q - CW'(do_pop);
        do_push = push_i && (wr_idx < CW'(DEPTH));
        count_d = count_q - CW'(do_pop) + CW'(do_push);
        mem_d   = mem_q;
        if (do_pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        if (do_push) begin
            mem_d[wr_idx] = wr_data_i;
        end
    end

    // Storage, occupancy and registered non-empty flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            valid_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            valid_q <= (count_d != '0);
            mem_q   <= mem_d;
        end
    end

    assign rd_data_o = mem_q[0];
    assign valid_o   = valid_q;
    assign count_o   = count_q;

endmodule : rom_burst_fifo

// File: rtl/rom_burst_reader.sv
// Burst reader for a 1-cycle-latency synchronous ROM. Reads are issued from
// RUN, tracked through a two-stage in-flight pipe (address register, ROM
// access) and captured into a 3-entry output FIFO.
// Optional feature: define ROM_BURST_STRIDE_EN to add a per-request address
// stride (req_stride); otherwise the stride is fixed at 1.
module rom_burst_reader
    import rom_burst_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
`ifdef ROM_BURST_STRIDE_EN
    input  logic [AW-1:0] req_stride,
`endif
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    // Occupancy width: FIFO count plus up to two reads in flight.
    localparam int unsigned OW = FIFO_CW + 1;

    state_e               state_q;
    logic [AW-1:0]        cur_addr_q;
    logic [LW-1:0]        remaining_q;
    logic [AW-1:0]        rom_addr_q;
    logic                 s1_v_q;
    logic                 s1_last_q;
    logic                 s2_v_q;
    logic                 s2_last_q;
    logic                 busy_q;
    logic                 req_ready_q;
    logic                 done_q;

    logic [FIFO_CW-1:0]   fifo_count;
    logic [DW:0]          fifo_head;
    logic                 fifo_valid;
    logic                 accept;
    logic                 pop;
    logic                 issue;
    logic                 issue_last;
    logic                 drain_done;
    logic [OW-1:0]        occupancy;
    logic [OW-1:0]        fill_after;
    logic [AW-1:0]        step;

`ifdef ROM_BURST_STRIDE_EN
    logic [AW-1:0]        stride_q;

    // Stride captured with the request.
    always_ff @(posedge clock) begin
        if (reset) begin
            stride_q <= '0;
        end else if (req_valid && req_ready_q) begin
            stride_q <= req_stride;
        end
    end

    assign step = stride_q;
`else
    assign step = AW'(1);
`endif

    // Issue gating counts this cycle's pop so a full-rate stream never bubbles.
    always_comb begin
        accept     = req_valid && req_ready_q;
        pop        = fifo_valid && out_ready;
        occupancy  = OW'(fifo_count) + OW'(s1_v_q) + OW'(s2_v_q) - OW'(pop);
        issue      = (state_q == RUN) && (occupancy < OW'(FIFO_DEPTH));
        issue_last = (remaining_q == LW'(1));
        fill_after = OW'(fifo_count) + OW'(s2_v_q) - OW'(pop);
        drain_done = (state_q == DRAIN) && !s1_v_q && (fill_after == '0);
    end

    // Control FSM, address generation and in-flight read tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rom_addr_q  <= '0;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            s2_v_q    <= s1_v_q;
            s2_last_q <= s1_last_q;
            s1_v_q    <= issue;
            s1_last_q <= issue && issue_last;

            if (issue) begin
                rom_addr_q  <= cur_addr_q;
                cur_addr_q  <= cur_addr_q + step;
                remaining_q <= remaining_q - LW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            cur_addr_q  <= req_addr;
                            remaining_q <= req_len;
                            busy_q      <= 1'b1;
                            req_ready_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (issue && issue_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Output buffer; the last-word tag travels as the top bit.
    rom_burst_fifo #(
        .W     (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_i    (s2_v_q),
        .wr_data_i ({s2_last_q, rom_q}),
        .pop_i     (pop),
        .rd_data_o (fifo_head),
        .valid_o   (fifo_valid),
        .count_o   (fifo_count)
    );

    assign req_ready = req_ready_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = fifo_valid;
    assign out_data  = fifo_head[DW-1:0];
    assign out_last  = fifo_head[DW];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : rom_burst_reader

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a ROM model holding ROM[i]=i[7:0].
module tb_rom_burst_reader;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic [15:0] req_stride;
    logic [15:0] rom_addr;
    logic [7:0]  rom_q;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int errors;
    int checks;

    rom_burst_reader #(.AW(16), .DW(8), .LW(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
`ifdef ROM_BURST_STRIDE_EN
        .req_stride(req_stride),
`endif
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clock) rom_q <= rom_addr[7:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic [15:0] addr, input logic [7:0] len, input logic [15:0] stride);
        @(negedge clock);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_len    = len;
        req_stride = stride;
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    // Runs one burst and scores every delivered word; stall selects ready 1,0,0,1,...
    task automatic run_burst(input logic [15:0] addr, input logic [7:0] len,
                             input logic [15:0] stride, input bit stall, input bit want_wrap);
        int got;
        int first_v;
        int done_at;
        int last_at;
        int max_cnt;
        int extra;
        bit prev_stall;
        bit saw_zero;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [7:0] exp_data;
        got = 0; first_v = 0; done_at = 0; last_at = 0; max_cnt = 0; extra = 0;
        prev_stall = 1'b0; saw_zero = 1'b0; prev_data = '0; prev_last = 1'b0;
        send_req(addr, len, stride);
        for (int k = 1; k <= 300 && done_at == 0; k++) begin
            @(negedge clock);
            out_ready = stall ? ((k % 3) == 1) : 1'b1;
            if (k == 1) begin
                chk("busy_start", 32'(busy), 32'(len != 8'd0));
                chk("req_ready_run", 32'(req_ready), 32'(len == 8'd0));
            end
            if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
            if (rom_addr == 16'h0000) saw_zero = 1'b1;
            if (prev_stall) begin
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && first_v == 0) first_v = k;
            if (done) begin
                done_at = k;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            if (out_valid && out_ready) begin
                exp_data = 8'(addr + 16'(got) * stride);
                chk("data", 32'(out_data), 32'(exp_data));
                chk("last", 32'(out_last), 32'(got == int'(len) - 1));
                if (!stall) chk("word_cycle", 32'(k), 32'(4 + got));
                if (got == int'(len) - 1) last_at = k;
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        chk("word_count", 32'(got), 32'(len));
        chk("done_cycle", 32'(done_at), 32'(last_at + 1));
        if (!stall) chk("first_valid", 32'(first_v), (len == 8'd0) ? 32'd0 : 32'd4);
        chk("fifo_max_ok", 32'(max_cnt <= 3), 32'd1);
        if (want_wrap) chk("rom_addr_wrap", 32'(saw_zero), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (done || out_valid) extra++;
        end
        chk("post_quiet", 32'(extra), 32'd0);
    endtask

    initial begin
        int quiet;
        errors = 0;
        checks = 0;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        req_stride = 16'd1; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);

        run_burst(16'h0010, 8'd4, 16'd1, 1'b0, 1'b0);
        run_burst(16'hFFFE, 8'd4, 16'd1, 1'b0, 1'b1);
        run_burst(16'h0030, 8'd6, 16'd1, 1'b1, 1'b0);
        run_burst(16'h0050, 8'd0, 16'd1, 1'b0, 1'b0);

        // Reset during the third word of an 8-word burst.
        send_req(16'h0020, 8'd8, 16'd1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            out_ready = 1'b1;
        end
        chk("abort_pre_valid", 32'(out_valid), 32'd1);
        chk("abort_pre_data", 32'(out_data), 32'h22);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock) reset = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        quiet = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (done || out_valid) quiet++;
        end
        chk("abort_quiet", 32'(quiet), 32'd0);
        run_burst(16'h0040, 8'd2, 16'd1, 1'b0, 1'b0);

`ifdef ROM_BURST_STRIDE_EN
        run_burst(16'h0000, 8'd3, 16'd4, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rom_burst_reader
